fetch_pc_unit: RTL and testbench

Fetch-stage next-PC generator that sits directly upstream of `branch_predictor`. It owns the architectural PC register and drives the `pc` that the predictor and instruction cache consume. Each cycle it picks the next PC from four sources: the predictor's taken prediction, sequential PC+4, a late recovery from the M stage, or a held value during stalls. A one-entry pending-redirect buffer ensures no recovery is lost while the pipeline is stalled.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/sat_counter.sv | 23 ++
 rtl/fetch_pc_unit.sv | 121 ++++++++++++
 tb/tb_fetch_pc_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and next-PC source encoding for the fetch stage
package fetch_pkg;

  localparam logic [6:0]  OPC_BRANCH       = 7'b1100011;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [2:0] {
    NPC_HOLD,
    NPC_RECOVER,
    NPC_PEND,
    NPC_PRED,
    NPC_SEQ
  } npc_sel_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter, sticks at all-ones
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign count = r_count;

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - fetch-stage next-PC generator with one-entry pending redirect
// Optional statistics counters are built when FETCH_PC_STATS_EN is defined.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC),
  parameter int                    CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss,
  input  logic                  load_use_flag,
  input  logic                  branch_F,
  input  logic                  prediction_F,
  input  logic [DATA_WIDTH-1:0] label_F,
  input  logic                  branch_M,
  input  logic                  pcsrc_M,
  input  logic [DATA_WIDTH-1:0] pc_branch_M,
  input  logic                  correct_M,
  input  logic                  error_M,
  input  logic [DATA_WIDTH-1:0] new_label_M,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] pc_plus4,
  output logic                  redirect,
  output logic [CNT_WIDTH-1:0]  branch_cnt,
  output logic [CNT_WIDTH-1:0]  mispredict_cnt
);

  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~{{(DATA_WIDTH-2){1'b0}}, 2'b11};
  localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);

  logic [DATA_WIDTH-1:0] r_pc;
  logic                  r_pend_valid;
  logic [DATA_WIDTH-1:0] r_pend_pc;

  logic                  w_stall;
  logic                  w_live;
  logic [DATA_WIDTH-1:0] w_live_pc;
  logic [DATA_WIDTH-1:0] w_pc_plus4;
  logic [DATA_WIDTH-1:0] w_npc;
  npc_sel_t              w_sel;

  assign w_stall    = miss | load_use_flag;
  // A predicted-taken-but-not-taken recovery outranks a taken-but-mispredicted one.
  assign w_live     = error_M | (pcsrc_M & ~correct_M);
  assign w_live_pc  = (error_M ? new_label_M : pc_branch_M) & ALIGN_MASK;
  assign w_pc_plus4 = r_pc + PC_STEP;

  always_comb begin
    w_sel = NPC_SEQ;
    if (w_stall) begin
      w_sel = NPC_HOLD;
    end else if (w_live) begin
      w_sel = NPC_RECOVER;
    end else if (r_pend_valid) begin
      w_sel = NPC_PEND;
    end else if (branch_F && prediction_F) begin
      w_sel = NPC_PRED;
    end
  end

  always_comb begin
    w_npc = w_pc_plus4;
    case (w_sel)
      NPC_HOLD:    w_npc = r_pc;
      NPC_RECOVER: w_npc = w_live_pc;
      NPC_PEND:    w_npc = r_pend_pc;
      NPC_PRED:    w_npc = label_F & ALIGN_MASK;
      NPC_SEQ:     w_npc = w_pc_plus4;
      default:     w_npc = w_pc_plus4;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_npc;
    end
  end

  // Any unstalled cycle consumes the buffer, either directly or because a live recovery supersedes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend_valid <= 1'b0;
      r_pend_pc    <= '0;
    end else if (w_stall && w_live) begin
      r_pend_valid <= 1'b1;
      r_pend_pc    <= w_live_pc;
    end else if (!w_stall) begin
      r_pend_valid <= 1'b0;
    end
  end

  assign pc       = r_pc;
  assign pc_plus4 = w_pc_plus4;
  assign redirect = ~w_stall & (w_live | r_pend_valid);

`ifdef FETCH_PC_STATS_EN
  sat_counter #(.WIDTH(CNT_WIDTH)) u_branch_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (branch_M & ~miss),
    .count (branch_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_mispredict_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_live & ~miss),
    .count (mispredict_cnt)
  );
`else
  logic w_unused_stats;
  assign w_unused_stats = branch_M;
  assign branch_cnt     = '0;
  assign mispredict_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed table-driven bench for fetch_pc_unit and sat_counter
module tb_fetch_pc_unit;

  typedef struct {
    logic        miss;
    logic        luf;
    logic        bf;
    logic        pf;
    logic [31:0] lab;
    logic        bm;
    logic        pcs;
    logic [31:0] pcb;
    logic        cor;
    logic        err;
    logic [31:0] nl;
    logic        rd;
    logic [31:0] npc;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        miss, load_use_flag, branch_F, prediction_F;
  logic [31:0] label_F;
  logic        branch_M, pcsrc_M, correct_M, error_M;
  logic [31:0] pc_branch_M, new_label_M;
  logic [31:0] pc, pc_plus4;
  logic        redirect;
  logic [31:0] branch_cnt, mispredict_cnt;

  logic        sc_rst, sc_inc;
  logic [1:0]  sc_count;

  int          checks;
  int          errors;
  logic [31:0] cur_pc;
  vec_t        tbl[$];

  fetch_pc_unit dut (
    .clk            (clk),
    .rst            (rst),
    .miss           (miss),
    .load_use_flag  (load_use_flag),
    .branch_F       (branch_F),
    .prediction_F   (prediction_F),
    .label_F        (label_F),
    .branch_M       (branch_M),
    .pcsrc_M        (pcsrc_M),
    .pc_branch_M    (pc_branch_M),
    .correct_M      (correct_M),
    .error_M        (error_M),
    .new_label_M    (new_label_M),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .redirect       (redirect),
    .branch_cnt     (branch_cnt),
    .mispredict_cnt (mispredict_cnt)
  );

  sat_counter #(.WIDTH(2)) u_sc2 (
    .clk   (clk),
    .rst   (sc_rst),
    .inc   (sc_inc),
    .count (sc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic m, input logic l, input logic bf, input logic pf,
                              input logic [31:0] lab, input logic bm, input logic pcs,
                              input logic [31:0] pcb, input logic cor, input logic err,
                              input logic [31:0] nl, input logic rd, input logic [31:0] npc);
    vec_t v;
    v.miss = m; v.luf = l; v.bf = bf; v.pf = pf; v.lab = lab; v.bm = bm; v.pcs = pcs;
    v.pcb = pcb; v.cor = cor; v.err = err; v.nl = nl; v.rd = rd; v.npc = npc;
    return v;
  endfunction

  function automatic vec_t idle(input logic [31:0] npc);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, npc);
  endfunction

  task automatic drive_idle();
    miss = 0; load_use_flag = 0; branch_F = 0; prediction_F = 0; label_F = 0;
    branch_M = 0; pcsrc_M = 0; pc_branch_M = 0; correct_M = 0; error_M = 0; new_label_M = 0;
  endtask

  // Called just after a posedge: drive, check combinational outputs, clock, check new pc.
  task automatic run_vec(input vec_t v, input string name);
    miss = v.miss; load_use_flag = v.luf; branch_F = v.bf; prediction_F = v.pf;
    label_F = v.lab; branch_M = v.bm; pcsrc_M = v.pcs; pc_branch_M = v.pcb;
    correct_M = v.cor; error_M = v.err; new_label_M = v.nl;
    #1;
    chk({name, ".pc"}, pc, cur_pc);
    chk({name, ".pc_plus4"}, pc_plus4, cur_pc + 32'd4);
    chk({name, ".redirect"}, {31'b0, redirect}, {31'b0, v.rd});
    @(posedge clk);
    #1;
    chk({name, ".npc"}, pc, v.npc);
    cur_pc = v.npc;
  endtask

  task automatic do_reset();
    #3;
    rst = 0;
    #1;
    chk("reset_async_pc", pc, 32'h0);
    @(posedge clk);
    #1;
    rst = 1;
    cur_pc = 32'h0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 0;
    sc_rst = 0;
    sc_inc = 0;
    drive_idle();
    cur_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("run_before_reset_pc", pc, 32'h0000_000C);

    do_reset();
    chk("post_reset_pc", pc, 32'h0);
    chk("reset_branch_cnt", branch_cnt, 32'h0);
    chk("reset_mispredict_cnt", mispredict_cnt, 32'h0);

    tbl.push_back(idle(32'h04));
    tbl.push_back(idle(32'h08));
    tbl.push_back(idle(32'h0C));
    tbl.push_back(idle(32'h10));
    tbl.push_back(mk(0, 0, 1, 1, 32'h40, 0, 0, 0, 0, 0, 0, 0, 32'h40));
    tbl.push_back(mk(0, 0, 1, 0, 32'h80, 0, 0, 0, 0, 0, 0, 0, 32'h44));
    tbl.push_back(mk(0, 0, 1, 1, 32'h80, 0, 0, 0, 0, 1, 32'h24, 1, 32'h24));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h103, 0, 0, 0, 1, 32'h100));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h200, 1, 0, 0, 0, 32'h104));
    tbl.push_back(mk(0, 1, 1, 1, 32'h80, 0, 0, 0, 0, 0, 0, 0, 32'h104));
    tbl.push_back(mk(0, 0, 1, 1, 32'h52, 0, 0, 0, 0, 0, 0, 0, 32'h50));
    for (int i = 0; i < tbl.size(); i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // Recovery during a three-cycle miss is held, then applied.
    run_vec(mk(1, 0, 0, 0, 0, 0, 1, 32'h100, 0, 0, 0, 0, 32'h50), "miss_rec0");
    run_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h50), "miss_rec1");
    run_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h50), "miss_rec2");
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100), "miss_rec3");
    run_vec(idle(32'h104), "miss_rec4");

    // A newer recovery during a stall overwrites the buffer.
    run_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h300, 0, 32'h104), "ovw0");
    run_vec(mk(1, 0, 0, 0, 0, 0, 1, 32'h400, 0, 0, 0, 0, 32'h104), "ovw1");
    run_vec(mk(0, 0, 1, 1, 32'h80, 0, 0, 0, 0, 0, 0, 1, 32'h400), "ovw2");
    run_vec(idle(32'h404), "ovw3");

    // A live recovery beats the pending one, and the buffer is dropped.
    run_vec(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h500, 0, 32'h404), "live0");
    run_vec(mk(0, 0, 0, 0, 0, 0, 1, 32'h600, 0, 0, 0, 1, 32'h600), "live1");
    run_vec(idle(32'h604), "live2");

    // Wrap-around from the top of the address space.
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC), "wrap0");
    run_vec(idle(32'h0), "wrap1");

    // Reset while a redirect is pending discards it.
    run_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h700, 0, 32'h0), "rstpend0");
    drive_idle();
    do_reset();
    run_vec(idle(32'h4), "rstpend1");

    // Statistics after a fresh reset.
    drive_idle();
    do_reset();
    run_vec(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h04), "st0");
    run_vec(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h20, 1, 32'h20), "st1");
    run_vec(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h24), "st2");
    run_vec(mk(0, 0, 0, 0, 0, 1, 1, 32'h80, 1, 0, 0, 0, 32'h28), "st3");
    run_vec(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h40, 1, 32'h40), "st4");
    run_vec(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h40), "st5");
    run_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h60, 0, 32'h40), "st6");
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h60), "st7");
`ifdef FETCH_PC_STATS_EN
    chk("stats_branch_cnt", branch_cnt, 32'd5);
    chk("stats_mispredict_cnt", mispredict_cnt, 32'd2);
`else
    chk("stats_off_branch_cnt", branch_cnt, 32'd0);
    chk("stats_off_mispredict_cnt", mispredict_cnt, 32'd0);
`endif

    // Two-bit saturating counter: 2 increments then 3 more.
    sc_rst = 1;
    chk("sc_reset", {30'b0, sc_count}, 32'd0);
    sc_inc = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("sc_count2", {30'b0, sc_count}, 32'd2);
    repeat (3) @(posedge clk);
    #1;
    chk("sc_saturate", {30'b0, sc_count}, 32'd3);
    sc_inc = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
